// File: rtl/music_sequencer.sv
// Beat sequencer and tone register: steps a quarter-beat index through an
// external song ROM and registers the returned tone for the PWM generator.
// Adds play/pause/stop control, loop or one-shot mode, song switching at loop
// boundaries and a short silent gap between repeated notes.
module music_sequencer #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BEAT_HZ    = 8,
  parameter int unsigned BEAT_W     = 10,
  parameter int unsigned SONG_W     = 2,
  parameter logic [31:0] SILENCE    = 32'd20000,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [SONG_W-1:0] song_sel,
  input  logic [BEAT_W-1:0] song_len,
  input  logic [31:0]       tone_in,
  output logic [BEAT_W-1:0] beat_num,
  output logic [SONG_W-1:0] song_out,
  output logic [31:0]       tone_out,
  output logic              beat_tick,
  output logic              playing,
  output logic              done
);

  localparam int unsigned DIV   = CLK_HZ / BEAT_HZ;
  localparam int unsigned DIV_W = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BEAT_W-1:0] len_r;
  logic [31:0]       prev_tone;
  logic [31:0]       gap_cnt;
  logic              beat_start;
  logic              gap_hit;
  logic              gap_active;
  logic              div_end;
  logic              last_beat;

  // Repeated-note detection on the first playing cycle of each beat.
  always_comb begin
    gap_hit    = (GAP_CYCLES != 0) && beat_start &&
                 (tone_in == prev_tone) && (tone_in != SILENCE);
    gap_active = gap_hit || (gap_cnt != '0);
    div_end    = (div_cnt == DIV_W'(DIV - 1));
    last_beat  = (beat_num == len_r - BEAT_W'(1));
  end

  // Control FSM, beat divider, song latch and tone register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      beat_num   <= '0;
      song_out   <= '0;
      len_r      <= '0;
      tone_out   <= SILENCE;
      beat_tick  <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
      prev_tone  <= SILENCE;
      gap_cnt    <= '0;
      beat_start <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      tone_out  <= SILENCE;
      if (state == PLAY) begin
        tone_out <= gap_active ? SILENCE : tone_in;
      end

      case (state)
        IDLE, DONE: begin
          if (stop) begin
            state   <= IDLE;
            done    <= 1'b0;
            playing <= 1'b0;
          end else if (!pause && play && (song_len != '0)) begin
            state      <= PLAY;
            playing    <= 1'b1;
            done       <= 1'b0;
            song_out   <= song_sel;
            len_r      <= song_len;
            beat_num   <= '0;
            div_cnt    <= '0;
            prev_tone  <= SILENCE;
            gap_cnt    <= '0;
            beat_start <= 1'b1;
          end
        end

        PLAY: begin
          prev_tone <= tone_in;
          if (beat_start) begin
            beat_start <= 1'b0;
            gap_cnt    <= gap_hit ? GAP_CYCLES - 1 : '0;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 32'd1;
          end

          if (stop) begin
            state      <= IDLE;
            playing    <= 1'b0;
            beat_num   <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            beat_start <= 1'b0;
          end else if (div_end) begin
            div_cnt   <= '0;
            beat_tick <= 1'b1;
            if (loop_en && last_beat) begin
              song_out <= song_sel;
              len_r    <= song_len;
            end
            // A beat advance that ends the song wins over a concurrent pause.
            if (!last_beat || (loop_en && (song_len != '0))) begin
              beat_num   <= last_beat ? '0 : beat_num + BEAT_W'(1);
              beat_start <= 1'b1;
              if (pause) begin
                state   <= PAUSE;
                playing <= 1'b0;
              end
            end else begin
              state      <= DONE;
              playing    <= 1'b0;
              done       <= 1'b1;
              beat_num   <= '0;
              gap_cnt    <= '0;
              beat_start <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            if (pause) begin
              state   <= PAUSE;
              playing <= 1'b0;
            end
          end
        end

        PAUSE: begin
          if (stop) begin
            state      <= IDLE;
            beat_num   <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            beat_start <= 1'b0;
          end else if (!pause && play) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
